// File: rtl/tx_unpacker.sv
// TX-side unpacker: pops one frame of packed 16-bit words from a show-ahead FIFO per
// txstrobe and presents them on eight channel outputs, with sticky underrun/collision flags.
`timescale 1ns/1ps
module tx_unpacker #(
    parameter int FIFO_AW = 12
) (
    input  logic               txclk,
    input  logic               reset,
    input  logic               txstrobe,
    input  logic [3:0]         channels,
    input  logic               bitwidth_8,
    input  logic               clear_status,
    input  logic [15:0]        fifo_q,
    input  logic               fifo_empty,
    input  logic [FIFO_AW-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    output logic [15:0]        ch_0,
    output logic [15:0]        ch_1,
    output logic [15:0]        ch_2,
    output logic [15:0]        ch_3,
    output logic [15:0]        ch_4,
    output logic [15:0]        ch_5,
    output logic [15:0]        ch_6,
    output logic [15:0]        ch_7,
    output logic               frame_done,
    output logic               tx_underrun,
    output logic               strobe_collision,
    output logic [15:0]        debugbus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    nwords_q, nwords_d;
    logic [3:0]    nch_q, nch_d;
    logic          bw8_q, bw8_d;
    logic          frame_done_q, frame_done_d;
    logic          underrun_q, underrun_d;
    logic          collision_q, collision_d;

    logic          in_idle;
    logic          in_load;
    logic          chan_ok;
    logic [3:0]    req_words;
    logic          short_fifo;
    logic          underrun_start;
    logic          frame_start;
    logic          load_last;
    logic [15:0]   cap_word;
    logic [127:0]  ch_flat;

    assign in_idle   = (state_q == S_IDLE);
    assign in_load   = (state_q == S_LOAD);
    assign chan_ok   = (channels != 4'd0) && (channels <= 4'd8);
    // 8-bit mode packs two channels per word, so an odd count rounds up.
    assign req_words = bitwidth_8 ? ((channels >> 1) + {3'b000, channels[0]}) : channels;
    assign short_fifo     = (fifo_usedw < FIFO_AW'(req_words));
    assign underrun_start = in_idle & txstrobe & chan_ok & short_fifo;
    assign frame_start    = in_idle & txstrobe & chan_ok & ~short_fifo;
    assign load_last      = (idx_q == (nwords_q - 4'd1));
    assign cap_word       = fifo_empty ? 16'h0000 : fifo_q;

    always_comb begin
        state_d    = state_q;
        fifo_rdreq = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                fifo_rdreq = 1'b1;
                if (load_last) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        idx_d        = idx_q;
        nwords_d     = nwords_q;
        nch_d        = nch_q;
        bw8_d        = bw8_q;
        frame_done_d = (state_q == S_COMMIT);
        if (frame_start) begin
            idx_d    = 4'd0;
            nwords_d = req_words;
            nch_d    = channels;
            bw8_d    = bitwidth_8;
        end else if (in_load) begin
            idx_d = idx_q + 4'd1;
        end
        // A set event in the same cycle as clear_status wins.
        if (underrun_start || (in_load && fifo_empty)) begin
            underrun_d = 1'b1;
        end else if (clear_status) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
        if (txstrobe && !in_idle) begin
            collision_d = 1'b1;
        end else if (clear_status) begin
            collision_d = 1'b0;
        end else begin
            collision_d = collision_q;
        end
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            nwords_q     <= 4'd0;
            nch_q        <= 4'd0;
            bw8_q        <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            nwords_q     <= nwords_d;
            nch_q        <= nch_d;
            bw8_q        <= bw8_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            collision_q  <= collision_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        localparam logic [3:0] CH_IDX   = 4'(gi);
        localparam logic [3:0] WORD_IDX = 4'(gi / 2);

        logic [15:0] shadow_q;
        logic [15:0] ch_q;
        logic        wr16;
        logic        wr8;
        logic [15:0] byte_val;

        assign wr16     = in_load & ~bw8_q & (idx_q == CH_IDX);
        assign wr8      = in_load &  bw8_q & (idx_q == WORD_IDX);
        assign byte_val = (gi % 2 == 1) ? {cap_word[15:8], 8'h00} : {cap_word[7:0], 8'h00};

        always_ff @(posedge txclk or negedge reset) begin
            if (!reset) begin
                shadow_q <= 16'h0000;
                ch_q     <= 16'h0000;
            end else begin
                if (wr16) begin
                    shadow_q <= cap_word;
                end else if (wr8) begin
                    shadow_q <= byte_val;
                end
                if (underrun_start) begin
                    ch_q <= 16'h0000;
                end else if (state_q == S_COMMIT) begin
                    ch_q <= (CH_IDX < nch_q) ? shadow_q : 16'h0000;
                end
            end
        end

        assign ch_flat[gi*16 +: 16] = ch_q;
    end

    assign ch_0 = ch_flat[15:0];
    assign ch_1 = ch_flat[31:16];
    assign ch_2 = ch_flat[47:32];
    assign ch_3 = ch_flat[63:48];
    assign ch_4 = ch_flat[79:64];
    assign ch_5 = ch_flat[95:80];
    assign ch_6 = ch_flat[111:96];
    assign ch_7 = ch_flat[127:112];

    assign frame_done       = frame_done_q;
    assign tx_underrun      = underrun_q;
    assign strobe_collision = collision_q;
    assign debugbus         = {7'd0, txstrobe, underrun_q, fifo_rdreq, idx_q, state_q};

endmodule

// File: tb/tb_tx_unpacker.sv
// Bench for tx_unpacker: queue-based show-ahead FIFO model, directed frames plus
// randomized frames checked against a byte-stream reference model.
`timescale 1ns/1ps
module tb_tx_unpacker;

    localparam int FIFO_AW = 12;

    typedef logic [15:0] word8_t [8];

    logic               txclk;
    logic               reset;
    logic               txstrobe;
    logic [3:0]         channels;
    logic               bitwidth_8;
    logic               clear_status;
    logic [15:0]        fifo_q;
    logic               fifo_empty;
    logic [FIFO_AW-1:0] fifo_usedw;
    logic               fifo_rdreq;
    logic [15:0]        ch_0, ch_1, ch_2, ch_3, ch_4, ch_5, ch_6, ch_7;
    logic               frame_done;
    logic               tx_underrun;
    logic               strobe_collision;
    logic [15:0]        debugbus;

    logic [15:0] ch_obs [8];
    logic [15:0] fq [$];
    int          pops;
    int          vectors;
    int          miscompares;

    tx_unpacker #(.FIFO_AW(FIFO_AW)) dut (
        .txclk            (txclk),
        .reset            (reset),
        .txstrobe         (txstrobe),
        .channels         (channels),
        .bitwidth_8       (bitwidth_8),
        .clear_status     (clear_status),
        .fifo_q           (fifo_q),
        .fifo_empty       (fifo_empty),
        .fifo_usedw       (fifo_usedw),
        .fifo_rdreq       (fifo_rdreq),
        .ch_0             (ch_0),
        .ch_1             (ch_1),
        .ch_2             (ch_2),
        .ch_3             (ch_3),
        .ch_4             (ch_4),
        .ch_5             (ch_5),
        .ch_6             (ch_6),
        .ch_7             (ch_7),
        .frame_done       (frame_done),
        .tx_underrun      (tx_underrun),
        .strobe_collision (strobe_collision),
        .debugbus         (debugbus)
    );

    assign ch_obs[0] = ch_0;
    assign ch_obs[1] = ch_1;
    assign ch_obs[2] = ch_2;
    assign ch_obs[3] = ch_3;
    assign ch_obs[4] = ch_4;
    assign ch_obs[5] = ch_5;
    assign ch_obs[6] = ch_6;
    assign ch_obs[7] = ch_7;

    always #5 txclk = ~txclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fq.size() == 0);
        fifo_q     = (fq.size() > 0) ? fq[0] : 16'h0000;
        fifo_usedw = FIFO_AW'(fq.size());
    endtask

    task automatic push_word(input logic [15:0] w);
        fq.push_back(w);
        fifo_refresh();
    endtask

    // One clock: a pop requested during this cycle takes effect at the edge.
    task automatic cyc();
        logic pop;
        pop = fifo_rdreq;
        @(posedge txclk);
        #1;
        if (pop) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pops++;
        end
        fifo_refresh();
    endtask

    // Channel i takes byte i of the word stream (low byte first) in 8-bit mode,
    // or word i in 16-bit mode; channels beyond the count are zero.
    function automatic word8_t model_expect(input int nch, input logic bw8, input word8_t words);
        word8_t     e;
        logic [7:0] bytes [16];
        for (int k = 0; k < 8; k++) begin
            bytes[2*k]   = words[k][7:0];
            bytes[2*k+1] = words[k][15:8];
        end
        for (int i = 0; i < 8; i++) begin
            if (i >= nch)  e[i] = 16'h0000;
            else if (bw8)  e[i] = {bytes[i], 8'h00};
            else           e[i] = words[i];
        end
        return e;
    endfunction

    // Strobe in cycle T (with clear_status), optional second strobe at T+coll_at.
    task automatic run_frame(input logic [3:0] nch, input logic bw8, input int coll_at, input string tag);
        int     n, first_rd, last_rd, rd_cnt, done_at, pops0;
        logic   exp_coll;
        word8_t words;
        word8_t exp_ch;
        n = bw8 ? (int'(nch) + 1) / 2 : int'(nch);
        for (int i = 0; i < 8; i++) words[i] = (i < fq.size()) ? fq[i] : 16'h0000;
        exp_ch   = model_expect(int'(nch), bw8, words);
        exp_coll = (coll_at >= 1) && (coll_at <= n + 1);
        pops0 = pops; first_rd = -1; last_rd = -1; rd_cnt = 0; done_at = -1;
        channels = nch; bitwidth_8 = bw8; txstrobe = 1'b1; clear_status = 1'b1;
        for (int t = 1; t <= 30 && done_at < 0; t++) begin
            cyc();
            clear_status = 1'b0;
            txstrobe     = (t == coll_at);
            channels     = 4'($urandom_range(0, 15));
            bitwidth_8   = 1'($urandom_range(0, 1));
            if (fifo_rdreq) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = t;
                last_rd = t;
            end
            if (frame_done) done_at = t;
        end
        txstrobe = 1'b0;
        check({tag, "_done_latency"}, 32'(done_at), 32'(n + 2));
        check({tag, "_rd_first"},     32'(first_rd), 32'd1);
        check({tag, "_rd_last"},      32'(last_rd), 32'(n));
        check({tag, "_rd_count"},     32'(rd_cnt), 32'(n));
        check({tag, "_pops"},         32'(pops - pops0), 32'(n));
        for (int i = 0; i < 8; i++) check($sformatf("%s_ch%0d", tag, i), 32'(ch_obs[i]), 32'(exp_ch[i]));
        check({tag, "_underrun"},  32'(tx_underrun), 32'd0);
        check({tag, "_collision"}, 32'(strobe_collision), 32'(exp_coll));
        cyc();
        check({tag, "_done_pulse_end"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int pops0, fd;
        int nch_r, n_r, coll_r;
        logic bw_r;
        vectors = 0; miscompares = 0; pops = 0;
        txclk = 1'b0; reset = 1'b0; txstrobe = 1'b0; channels = 4'd0;
        bitwidth_8 = 1'b0; clear_status = 1'b0;
        fifo_refresh();
        repeat (2) @(posedge txclk);
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("rst_ch%0d", i), 32'(ch_obs[i]), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_rdreq",      32'(fifo_rdreq), 32'd0);
        check("rst_underrun",   32'(tx_underrun), 32'd0);
        check("rst_collision",  32'(strobe_collision), 32'd0);
        check("rst_debugbus",   32'(debugbus), 32'd0);
        reset = 1'b1;
        cyc();

        // 16-bit, four channels
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
        run_frame(4'd4, 1'b0, 0, "w16x4");
        check("w16x4_ch0_const", 32'(ch_0), 32'h1111);
        check("w16x4_ch3_const", 32'(ch_3), 32'h4444);

        // 8-bit, three channels: 0xDD discarded
        push_word(16'hBBAA); push_word(16'hDDCC);
        run_frame(4'd3, 1'b1, 0, "b8x3");
        check("b8x3_ch1_const", 32'(ch_1), 32'hBB00);
        check("b8x3_ch2_const", 32'(ch_2), 32'hCC00);
        check("b8x3_ch3_const", 32'(ch_3), 32'h0000);
        check("b8x3_fifo_left", 32'(fq.size()), 32'd0);

        // Underrun: two channels, one word available
        push_word(16'h7777);
        pops0 = pops;
        channels = 4'd2; bitwidth_8 = 1'b0; txstrobe = 1'b1;
        cyc();
        txstrobe = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("urun_ch%0d", i), 32'(ch_obs[i]), 32'd0);
        check("urun_flag",       32'(tx_underrun), 32'd1);
        check("urun_no_done",    32'(frame_done), 32'd0);
        check("urun_state_idle", 32'(debugbus[1:0]), 32'd0);
        check("urun_dbg_flag",   32'(debugbus[7]), 32'd1);
        repeat (4) cyc();
        check("urun_no_pops",    32'(pops - pops0), 32'd0);
        check("urun_sticky",     32'(tx_underrun), 32'd1);
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        check("urun_cleared",    32'(tx_underrun), 32'd0);
        clear_status = 1'b1; txstrobe = 1'b1;
        cyc();
        clear_status = 1'b0; txstrobe = 1'b0;
        check("urun_set_wins",   32'(tx_underrun), 32'd1);
        check("urun_no_coll",    32'(strobe_collision), 32'd0);
        fq.delete();
        fifo_refresh();

        // Collision during load: eight channels, second strobe at T+3
        for (int i = 0; i < 8; i++) push_word(16'h8001 + 16'(i));
        for (int i = 0; i < 8; i++) push_word(16'h9001 + 16'(i));
        run_frame(4'd8, 1'b0, 3, "coll_load");
        pops0 = pops; fd = 0;
        repeat (6) begin cyc(); if (frame_done) fd++; end
        check("coll_load_no_second_pops", 32'(pops - pops0), 32'd0);
        check("coll_load_no_second_done", 32'(fd), 32'd0);
        check("coll_load_fifo_left",      32'(fq.size()), 32'd8);

        // Strobe coincident with COMMIT is a collision and is not queued
        run_frame(4'd2, 1'b0, 3, "coll_commit");
        pops0 = pops; fd = 0;
        repeat (6) begin cyc(); if (frame_done) fd++; end
        check("coll_commit_no_second_pops", 32'(pops - pops0), 32'd0);
        check("coll_commit_no_second_done", 32'(fd), 32'd0);

        // Asynchronous reset in the middle of a four-word load
        fq.delete();
        for (int i = 0; i < 8; i++) push_word(16'h5001 + 16'(i));
        channels = 4'd4; bitwidth_8 = 1'b0; txstrobe = 1'b1;
        cyc();
        txstrobe = 1'b0;
        check("arst_rd_T1", 32'(fifo_rdreq), 32'd1);
        cyc();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("arst_ch%0d", i), 32'(ch_obs[i]), 32'd0);
        check("arst_rdreq",      32'(fifo_rdreq), 32'd0);
        check("arst_state_idle", 32'(debugbus[1:0]), 32'd0);
        check("arst_collision",  32'(strobe_collision), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        check("arst_fifo_left", 32'(fq.size()), 32'd7);
        run_frame(4'd4, 1'b0, 0, "arst_next");
        check("arst_next_ch0_const", 32'(ch_0), 32'h5002);

        // Illegal channel counts: nothing happens
        for (int k = 0; k < 2; k++) begin
            pops0 = pops; fd = 0;
            channels = (k == 0) ? 4'd0 : 4'd9; bitwidth_8 = 1'b0; txstrobe = 1'b1;
            cyc();
            txstrobe = 1'b0;
            repeat (6) begin cyc(); if (frame_done) fd++; end
            check($sformatf("badch%0d_pops", k),      32'(pops - pops0), 32'd0);
            check($sformatf("badch%0d_done", k),      32'(fd), 32'd0);
            check($sformatf("badch%0d_underrun", k),  32'(tx_underrun), 32'd0);
            check($sformatf("badch%0d_collision", k), 32'(strobe_collision), 32'd0);
        end

        // Randomized frames
        for (int it = 0; it < 16; it++) begin
            nch_r  = $urandom_range(1, 8);
            bw_r   = 1'($urandom_range(0, 1));
            n_r    = bw_r ? (nch_r + 1) / 2 : nch_r;
            coll_r = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n_r + 3) : 0;
            while (fq.size() < n_r + $urandom_range(0, 3)) push_word(16'($urandom));
            run_frame(4'(nch_r), bw_r, coll_r, $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
